// File: rtl/geofence_poly.sv
// Polygon geofence: loads an object and NV fence vertices, sorts the vertices
// angularly around vertex 0, then classifies the object edge by edge.
module geofence_poly #(
  parameter int CW = 10,
  parameter int NV = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          edge_mode,
  output logic          valid,
  output logic          is_inside,
  output logic          on_edge
);

  localparam int IW = $clog2(NV);
  localparam int DW = CW + 1;
  localparam int PW = 2 * CW + 3;
  localparam logic [IW-1:0] NVM1 = IW'(NV - 1);
  localparam logic [IW-1:0] NVM2 = IW'(NV - 2);
  localparam logic [IW-1:0] NVM3 = IW'(NV - 3);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    EVAL,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pass_q, pass_d;
  logic [CW-1:0] vx_q [NV];
  logic [CW-1:0] vy_q [NV];
  logic [CW-1:0] px_q, py_q;
  logic          mode_q;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          rdy_q, valid_q, inside_q, edge_q;
  logic          inside_d, edge_d;

  logic          xfer;
  logic [IW-1:0] j1, k;
  logic signed [PW-1:0] sc, ec;
  logic          swap;

  function automatic logic signed [DW-1:0] sdiff(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b
  );
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // ax*by - ay*bx at full width so nothing can overflow
  function automatic logic signed [PW-1:0] xprod(
    input logic signed [DW-1:0] ax,
    input logic signed [DW-1:0] ay,
    input logic signed [DW-1:0] bx,
    input logic signed [DW-1:0] by
  );
    logic signed [PW-1:0] m1, m2;
    m1 = PW'(ax) * PW'(by);
    m2 = PW'(ay) * PW'(bx);
    return m1 - m2;
  endfunction

  assign xfer = in_valid & rdy_q;
  assign j1   = cnt_q + IW'(1);
  assign k    = (cnt_q == NVM1) ? '0 : j1;

  assign sc = xprod(sdiff(vx_q[cnt_q], vx_q[0]),
                    sdiff(vy_q[cnt_q], vy_q[0]),
                    sdiff(vx_q[j1], vx_q[0]),
                    sdiff(vy_q[j1], vy_q[0]));
  assign swap = sc[PW-1];

  assign ec = xprod(sdiff(vx_q[cnt_q], px_q),
                    sdiff(vy_q[cnt_q], py_q),
                    sdiff(vx_q[k], vx_q[cnt_q]),
                    sdiff(vy_q[k], vy_q[cnt_q]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (cnt_q == NVM1) begin
            state_d = SORT;
            cnt_d   = IW'(1);
            pass_d  = '0;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      SORT: begin
        if (cnt_q == NVM2 - pass_q) begin
          if (pass_q == NVM3) begin
            state_d = EVAL;
            cnt_d   = '0;
            pos_d   = 1'b0;
            neg_d   = 1'b0;
            zero_d  = 1'b0;
          end else begin
            pass_d = pass_q + IW'(1);
            cnt_d  = IW'(1);
          end
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      EVAL: begin
        pos_d  = pos_q | (~ec[PW-1] & (|ec));
        neg_d  = neg_q | ec[PW-1];
        zero_d = zero_q | ~(|ec);
        if (cnt_q == NVM1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mixed signs means outside; a zero with one sign means on the boundary
  assign edge_d   = zero_d & ~(pos_d & neg_d);
  assign inside_d = zero_d ? (mode_q & ~(pos_d & neg_d)) : ~(pos_d & neg_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pass_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      mode_q   <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      rdy_q    <= 1'b0;
      valid_q  <= 1'b0;
      inside_q <= 1'b0;
      edge_q   <= 1'b0;
      for (int i = 0; i < NV; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      rdy_q    <= (state_d == IDLE) || (state_d == LOAD);
      valid_q  <= (state_d == DONE);
      inside_q <= (state_d == DONE) & inside_d;
      edge_q   <= (state_d == DONE) & edge_d;
      if (state_q == IDLE && xfer) begin
        px_q   <= X;
        py_q   <= Y;
        mode_q <= edge_mode;
      end
      if (state_q == LOAD && xfer) begin
        vx_q[cnt_q] <= X;
        vy_q[cnt_q] <= Y;
      end else if (state_q == SORT && swap) begin
        vx_q[cnt_q] <= vx_q[j1];
        vy_q[cnt_q] <= vy_q[j1];
        vx_q[j1]    <= vx_q[cnt_q];
        vy_q[j1]    <= vy_q[cnt_q];
      end
    end
  end

  assign in_ready  = rdy_q;
  assign valid     = valid_q;
  assign is_inside = inside_q;
  assign on_edge   = edge_q;

endmodule

// File: doc/geofence_poly.md
Name: geofence_poly

Overview:
- Parametrised successor of the fixed 6-vertex geofence checker.
- Per frame it accepts one test object and NV fence vertices in arbitrary order through a valid/ready handshake.
- It sorts the vertices angularly around vertex 0 with a sequential bubble sort, then evaluates one edge cross-product per cycle.
- It reports inside, outside or on-edge. It sits between the coordinate stream source and the alarm/logging logic.

Parameters:
- CW, 10, coordinate width in bits (unsigned X/Y).
- NV, 6, fence vertex count. Legal range 3..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  X/Y/edge_mode valid this cycle.
- in_ready  out  1  block accepts a coordinate this cycle.
- X  in  CW  X coordinate.
- Y  in  CW  Y coordinate.
- edge_mode  in  1  sampled with the object only; 1 = on-edge counts as inside.
- valid  out  1  one-cycle result strobe.
- is_inside  out  1  classification; meaningful only when valid=1.
- on_edge  out  1  object lies on a fence edge or vertex; meaningful only when valid=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counters cleared.
  - in_ready=0, valid=0, is_inside=0, on_edge=0.
  - Reset mid-frame discards everything; the next frame starts with the object word.
- Handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1. in_ready is a registered decode of state: 1 in IDLE and LOAD, 0 otherwise. in_valid low stalls without loss.
- States:
  - IDLE: the first transfer captures the object (X, Y, edge_mode) and goes to LOAD.
  - LOAD: NV transfers write vertex[0..NV-1] in arrival order. The cycle after the NV-th transfer the block enters SORT.
  - SORT: vertex[0] is the fixed pivot. Bubble-sort vertex[1..NV-1] with one compare/swap per cycle. Pass p (0..NV-3) compares j = 1 .. NV-2-p on the pair (vertex[j], vertex[j+1]).
    - Let A = vertex[j]-vertex[0] and B = vertex[j+1]-vertex[0].
    - Swap when Ax*By - Bx*Ay < 0. The result is counter-clockwise order with y up.
    - SORT lasts exactly S=(NV-1)(NV-2)/2 cycles (10 for NV=6, 1 for NV=3), then goes to EVAL.
  - EVAL: NV cycles, i = 0..NV-1, with k = (i+1) mod NV (wrap from NV-1 to 0).
    - c_i = (vertex[i]-P) x (vertex[k]-vertex[i]).
    - Record pos_i = c_i>0 and zero_i = c_i==0. Then go to DONE.
  - DONE: one cycle. valid=1 with registered is_inside/on_edge, then return to IDLE.
- Latency: valid is high in the (S+NV+1)-th cycle after the last vertex transfer edge (17 for NV=6). Throughput is one frame per 1+NV+S+NV+1 cycles minimum.
- Arithmetic:
  - Differences are sign-extended to CW+1 bits signed.
  - Products and the cross difference are computed at 2CW+3 bits signed, so no overflow is possible.
  - Comparisons are signed.
- Classification:
  - All zero_i=0 and all pos_i equal: is_inside=1, on_edge=0.
  - At least one zero_i=1 and all non-zero c_i share one sign: on_edge=1, is_inside=edge_mode.
  - Otherwise: is_inside=0, on_edge=0.
- Outside DONE, valid=0, is_inside=0 and on_edge=0.
- Precondition (not checked): vertices are distinct, form a convex polygon, and no three are collinear. Results for degenerate fences are undefined but the block must still return to IDLE on schedule.
- A vertex sequence already in CCW order causes no swaps. A fully reversed order must sort correctly in exactly S cycles.

Test Plan:
- NV=6, object (150,100), edge_mode=0, vertices (200,200),(100,0),(50,100),(250,100),(100,200),(200,0) -> valid pulse 17 cycles after the last transfer, is_inside=1, on_edge=0.
- Same fence, object (300,100) -> is_inside=0, on_edge=0. Same fence, object (0,0) -> is_inside=0.
- Same fence, object (150,0) -> with edge_mode=0: on_edge=1, is_inside=0; with edge_mode=1: on_edge=1, is_inside=1. Object (100,0) (vertex) -> on_edge=1.
- Backpressure: deassert in_valid for 3 cycles between vertices 2 and 3 -> no lost or duplicated vertex, same result. in_ready=0 from SORT through DONE; in_valid held high there is ignored.
- Reset pulse (reset=0, one cycle) during SORT -> valid never asserts for that frame; the next full frame classifies correctly.
- NV=4, CW=10, square (0,0),(1023,1023),(1023,0),(0,1023), object (512,512) -> is_inside=1 at S+NV+1=8 cycles. Object (1023,512) -> on_edge=1. Back-to-back frames with no idle gap -> both strobes correct.
